// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator input path: feeder FSM encoding,
// configuration register field offsets and default in-flight read depth.
package accel_pkg;

    // Feeder control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

    // Field offsets inside the configuration registers
    localparam int SHAPE_W_LSB  = 0;   // inputshape[7:0]   : width
    localparam int SHAPE_H_LSB  = 8;   // inputshape[15:8]  : height
    localparam int KSIZE_LSB    = 0;   // kernelshape[3:0]  : kernel size
    localparam int STRIDE_LSB   = 16;  // kernelsize[19:16] : stride

    localparam int SHAPE_FIELD_W  = 8;
    localparam int KSIZE_FIELD_W  = 4;
    localparam int STRIDE_FIELD_W = 4;

    // Default number of reads allowed in flight to the input buffer
    localparam int DEF_MAX_OUTSTANDING = 8;

    // A programmed stride of zero behaves like a stride of one
    function automatic logic [STRIDE_FIELD_W-1:0] eff_stride(input logic [STRIDE_FIELD_W-1:0] s);
        return (s == '0) ? STRIDE_FIELD_W'(1) : s;
    endfunction

endpackage

// File: rtl/feeder_addr_gen.sv
// Kernel-line-ordered address generator for the input feature map.
// Walks col 0..W-1, then kernel line 0..K-1, then row by stride S, and
// presents base + (row + kl)*W + col together with a flag marking the
// final address of the stream. Each step pulse advances one position.
module feeder_addr_gen
    import accel_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      step,
    input  logic [SHAPE_FIELD_W-1:0]  width,
    input  logic [SHAPE_FIELD_W-1:0]  height,
    input  logic [KSIZE_FIELD_W-1:0]  ksize,
    input  logic [STRIDE_FIELD_W-1:0] stride,
    input  logic [ADDR_WIDTH-1:0]     base,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic                      last,
    output logic [KSIZE_FIELD_W-1:0]  kline
);

    logic [SHAPE_FIELD_W-1:0]  col;
    logic [SHAPE_FIELD_W-1:0]  row;
    logic [KSIZE_FIELD_W-1:0]  kl;
    logic [STRIDE_FIELD_W-1:0] stride_eff;

    logic                      col_wrap;
    logic                      kl_wrap;
    logic                      row_end;
    logic [SHAPE_FIELD_W:0]    row_next_ext;
    logic [SHAPE_FIELD_W:0]    row_limit;
    logic [ADDR_WIDTH-1:0]     line_idx;

    assign stride_eff = eff_stride(stride);

    assign col_wrap = (col == width - SHAPE_FIELD_W'(1));
    assign kl_wrap  = (kl == ksize - KSIZE_FIELD_W'(1));

    // One extra bit so row + S cannot overflow before the compare. The
    // limit H - K is only meaningful for K <= H; the top level never
    // steps this block otherwise.
    assign row_next_ext = {1'b0, row} + (SHAPE_FIELD_W + 1)'(stride_eff);
    assign row_limit    = {1'b0, height} - (SHAPE_FIELD_W + 1)'(ksize);
    assign row_end      = (row_next_ext > row_limit);

    assign last  = col_wrap & kl_wrap & row_end;
    assign kline = kl;

    // Address math at full address width, wrapping modulo 2^ADDR_WIDTH
    assign line_idx = ADDR_WIDTH'(row) + ADDR_WIDTH'(kl);
    assign addr     = base + line_idx * ADDR_WIDTH'(width) + ADDR_WIDTH'(col);

    // Advance col, then kernel line, then row by stride on each step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            kl  <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            kl  <= '0;
            row <= '0;
        end else if (step) begin
            if (col_wrap) begin
                col <= '0;
                if (kl_wrap) begin
                    kl  <= '0;
                    row <= row_next_ext[SHAPE_FIELD_W-1:0];
                end else begin
                    kl <= kl + KSIZE_FIELD_W'(1);
                end
            end else begin
                col <= col + SHAPE_FIELD_W'(1);
            end
        end
    end

endmodule

// File: rtl/input_data_feeder.sv
// Responder for the conv2d engine's input-pixel requests. Each accepted
// request issues one registered read to the input buffer; returned words
// are passed straight back as o_data/o_data_vld while a stream is active.
// Reads in flight are capped at MAX_OUTSTANDING, with a single pending
// slot so a request arriving at the cap is issued once a slot frees.
// Optional debug visibility is built when INPUT_DATA_FEEDER_DBG_EN is
// defined; otherwise the debug outputs are tied to zero.
module input_data_feeder
    import accel_pkg::*;
#(
    parameter int BIT_WIDTH       = 8,
    parameter int NUM_CHANNEL     = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int REG_WIDTH       = 32,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [REG_WIDTH-1:0]             i_conf_ctrl,
    input  logic [REG_WIDTH-1:0]             i_conf_inputshape,
    input  logic [REG_WIDTH-1:0]             i_conf_kernelshape,
    input  logic [REG_WIDTH-1:0]             i_conf_kernelsize,
    input  logic [ADDR_WIDTH-1:0]            i_conf_inbase,
    input  logic                             i_data_req,
    input  logic                             i_data_end,
    output logic [BIT_WIDTH*NUM_CHANNEL-1:0] o_data,
    output logic                             o_data_vld,
    output logic [ADDR_WIDTH-1:0]            mem_radd,
    output logic                             mem_rden,
    input  logic [DATA_WIDTH-1:0]            mem_odat,
    input  logic                             mem_ovld,
    output logic                             o_done,
    output logic [REG_WIDTH-1:0]             o_dbg_knlinex_cnt,
    output logic [REG_WIDTH-1:0]             o_dbg_addr_reg
);

    localparam int PIX_W = BIT_WIDTH * NUM_CHANNEL;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] RUN   = ST_RUN;
    localparam logic [1:0] DRAIN = ST_DRAIN;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]                state;
    logic [1:0]                state_next;

    logic                      enable;
    logic [SHAPE_FIELD_W-1:0]  cfg_width;
    logic [SHAPE_FIELD_W-1:0]  cfg_height;
    logic [KSIZE_FIELD_W-1:0]  cfg_ksize;
    logic [STRIDE_FIELD_W-1:0] cfg_stride;
    logic                      degenerate;

    logic                      active;
    logic                      in_run;
    logic                      ovld_gated;
    logic                      slot_free;
    logic                      issue;
    logic                      retire;
    logic                      start;

    logic [CNT_W-1:0]          outstanding;
    logic                      pending;
    logic                      pending_next;

    logic [ADDR_WIDTH-1:0]     gen_addr;
    logic                      gen_last;
    logic [KSIZE_FIELD_W-1:0]  gen_kline;

    logic                      unused_bits;

    assign enable     = i_conf_ctrl[0];
    assign cfg_width  = i_conf_inputshape[SHAPE_W_LSB +: SHAPE_FIELD_W];
    assign cfg_height = i_conf_inputshape[SHAPE_H_LSB +: SHAPE_FIELD_W];
    assign cfg_ksize  = i_conf_kernelshape[KSIZE_LSB +: KSIZE_FIELD_W];
    assign cfg_stride = i_conf_kernelsize[STRIDE_LSB +: STRIDE_FIELD_W];

    // A kernel taller than the map, an empty row or a zero kernel yields no reads
    assign degenerate = (SHAPE_FIELD_W'(cfg_ksize) > cfg_height) ||
                        (cfg_width == '0) || (cfg_ksize == '0);

    assign in_run = (state == RUN);
    assign active = (state == RUN) || (state == DRAIN);
    assign start  = (state == IDLE) && enable;

    // Return path: memory data is only forwarded while a stream is live
    assign ovld_gated = mem_ovld & active;
    assign o_data_vld = ovld_gated;
    assign o_data     = active ? mem_odat[PIX_W-1:0] : '0;

    // A return in this cycle frees a slot for an issue in the same cycle
    assign slot_free = (outstanding != MAX_CNT) || ovld_gated;
    assign issue     = in_run && !degenerate && (i_data_req || pending) && slot_free;
    assign retire    = ovld_gated && (outstanding != '0);

    feeder_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start),
        .step   (issue),
        .width  (cfg_width),
        .height (cfg_height),
        .ksize  (cfg_ksize),
        .stride (cfg_stride),
        .base   (i_conf_inbase),
        .addr   (gen_addr),
        .last   (gen_last),
        .kline  (gen_kline)
    );

    // Next-state decode for the stream control FSM
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                if (degenerate || (issue && gen_last) || i_data_end) state_next = DRAIN;
            end
            DRAIN: begin
                if (outstanding == '0) state_next = DONE;
            end
            DONE: begin
                if (!enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pending slot: holds one request that could not issue; dropped when leaving RUN
    always_comb begin
        pending_next = 1'b0;
        if (in_run && (state_next == RUN)) begin
            if (issue) pending_next = pending && i_data_req;
            else       pending_next = pending || i_data_req;
        end
    end

    // FSM state, pending flag and stream-complete flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            o_done  <= (state_next == DONE);
        end
    end

    // Reads in flight: up on issue, down on a gated return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({issue, retire})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Registered read strobe; the address holds the most recent issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rden <= 1'b0;
            mem_radd <= '0;
        end else begin
            mem_rden <= issue;
            if (issue) mem_radd <= gen_addr;
        end
    end

`ifdef INPUT_DATA_FEEDER_DBG_EN
    logic [REG_WIDTH-1:0] dbg_addr;

    // Capture the address of every issued read for debug readout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_addr <= '0;
        end else if (issue) begin
            dbg_addr <= REG_WIDTH'(gen_addr);
        end
    end

    assign o_dbg_knlinex_cnt = REG_WIDTH'(gen_kline);
    assign o_dbg_addr_reg    = dbg_addr;
`else
    assign o_dbg_knlinex_cnt = '0;
    assign o_dbg_addr_reg    = '0;
`endif

    // Register bits outside the decoded fields are intentionally ignored
    assign unused_bits = ^{i_conf_ctrl, i_conf_inputshape, i_conf_kernelshape,
                           i_conf_kernelsize, mem_odat, gen_kline};

endmodule

// File: tb/tb_input_data_feeder.sv
// Directed testbench for input_data_feeder with a latency-1 memory model
// that can be stalled. Returned words are address ^ PAT so each beat
// identifies the read it answers.
module tb_input_data_feeder;

    localparam int BIT_WIDTH   = 8;
    localparam int NUM_CHANNEL = 3;
    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int REG_WIDTH   = 32;
    localparam int PIX_W       = BIT_WIDTH * NUM_CHANNEL;
    localparam logic [31:0] PAT  = 32'h00A5_5A3C;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic                  clk;
    logic                  rst_n;
    logic [REG_WIDTH-1:0]  i_conf_ctrl;
    logic [REG_WIDTH-1:0]  i_conf_inputshape;
    logic [REG_WIDTH-1:0]  i_conf_kernelshape;
    logic [REG_WIDTH-1:0]  i_conf_kernelsize;
    logic [ADDR_WIDTH-1:0] i_conf_inbase;
    logic                  i_data_req;
    logic                  i_data_end;
    logic [PIX_W-1:0]      o_data;
    logic                  o_data_vld;
    logic [ADDR_WIDTH-1:0] mem_radd;
    logic                  mem_rden;
    logic [DATA_WIDTH-1:0] mem_odat;
    logic                  mem_ovld;
    logic                  o_done;
    logic [REG_WIDTH-1:0]  o_dbg_knlinex_cnt;
    logic [REG_WIDTH-1:0]  o_dbg_addr_reg;

    int n_cmp = 0;
    int n_err = 0;

    input_data_feeder #(
        .BIT_WIDTH       (BIT_WIDTH),
        .NUM_CHANNEL     (NUM_CHANNEL),
        .ADDR_WIDTH      (ADDR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .REG_WIDTH       (REG_WIDTH),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_conf_ctrl        (i_conf_ctrl),
        .i_conf_inputshape  (i_conf_inputshape),
        .i_conf_kernelshape (i_conf_kernelshape),
        .i_conf_kernelsize  (i_conf_kernelsize),
        .i_conf_inbase      (i_conf_inbase),
        .i_data_req         (i_data_req),
        .i_data_end         (i_data_end),
        .o_data             (o_data),
        .o_data_vld         (o_data_vld),
        .mem_radd           (mem_radd),
        .mem_rden           (mem_rden),
        .mem_odat           (mem_odat),
        .mem_ovld           (mem_ovld),
        .o_done             (o_done),
        .o_dbg_knlinex_cnt  (o_dbg_knlinex_cnt),
        .o_dbg_addr_reg     (o_dbg_addr_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: latency 1, in-order, optionally stalled
    logic [31:0] mem_q[$];
    logic [31:0] mem_pop;
    logic        mem_stall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q.delete();
            mem_ovld <= 1'b0;
            mem_odat <= '0;
        end else begin
            if (mem_rden) mem_q.push_back(mem_radd);
            if (!mem_stall && mem_q.size() > 0) begin
                mem_pop = mem_q.pop_front();
                mem_ovld <= 1'b1;
                mem_odat <= mem_pop ^ PAT;
            end else begin
                mem_ovld <= 1'b0;
            end
        end
    end

    // Monitor: logs issued addresses and returned pixels mid-cycle
    logic [31:0]      rd_log[256];
    logic [PIX_W-1:0] vd_log[256];
    int rd_cnt = 0;
    int vld_cnt = 0;

    always @(negedge clk) begin
        if (mem_rden === 1'b1) begin
            if (rd_cnt < 256) rd_log[rd_cnt] = mem_radd;
            rd_cnt++;
        end
        if (o_data_vld === 1'b1) begin
            if (vld_cnt < 256) vd_log[vld_cnt] = o_data;
            vld_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int w, input int h, input int k, input int s);
        i_conf_inputshape  = REG_WIDTH'((h << 8) | w);
        i_conf_kernelshape = REG_WIDTH'(k);
        i_conf_kernelsize  = REG_WIDTH'(s << 16);
        i_conf_inbase      = BASE;
    endtask

    task automatic start_run;
        i_conf_ctrl = 32'd1;
        tick();
    endtask

    task automatic stop_run;
        i_data_req  = 1'b0;
        i_data_end  = 1'b0;
        i_conf_ctrl = 32'd0;
        repeat (3) tick();
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (o_done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (mem_rden !== 1'b0) begin n_err++; $display("FAIL rst_rden: got %b expected 0", mem_rden); end
        n_cmp++; if (mem_radd !== 32'h0) begin n_err++; $display("FAIL rst_radd: got %h expected 0", mem_radd); end
        n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", o_done); end
        n_cmp++; if (o_data_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b expected 0", o_data_vld); end
        n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL rst_data: got %h expected 0", o_data); end
        n_cmp++; if (o_dbg_knlinex_cnt !== 32'h0) begin n_err++; $display("FAIL rst_dbg_kl: got %h expected 0", o_dbg_knlinex_cnt); end
        n_cmp++; if (o_dbg_addr_reg !== 32'h0) begin n_err++; $display("FAIL rst_dbg_addr: got %h expected 0", o_dbg_addr_reg); end
    endtask

    task automatic test_full_sweep;
        int rs, vs, cyc;
        logic [31:0] exp_a;
        logic [PIX_W-1:0] exp_d;
        setup(4, 4, 3, 1);
        rs = rd_cnt; vs = vld_cnt;
        start_run();
        cyc = 0;
        for (int i = 0; i < 24; i++) begin
            i_data_req = 1'b1;
            tick(); cyc++;
        end
        i_data_req = 1'b0;
        while (cyc < 26) begin tick(); cyc++; end
        n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL sweep_done_c26: got %b expected 0", o_done); end
        tick(); cyc++;
        n_cmp++; if (o_done !== 1'b1) begin n_err++; $display("FAIL sweep_done_c27: got %b expected 1", o_done); end
        n_cmp++; if (rd_cnt - rs !== 24) begin n_err++; $display("FAIL sweep_reads: got %0d expected 24", rd_cnt - rs); end
        n_cmp++; if (vld_cnt - vs !== 24) begin n_err++; $display("FAIL sweep_beats: got %0d expected 24", vld_cnt - vs); end
        for (int i = 0; i < 24; i++) begin
            exp_a = (i < 12) ? BASE + 32'(i) : BASE + 32'h4 + 32'(i - 12);
            exp_d = PIX_W'(exp_a ^ PAT);
            n_cmp++; if (rd_log[rs + i] !== exp_a) begin n_err++; $display("FAIL sweep_addr[%0d]: got %h expected %h", i, rd_log[rs + i], exp_a); end
            n_cmp++; if (vd_log[vs + i] !== exp_d) begin n_err++; $display("FAIL sweep_data[%0d]: got %h expected %h", i, vd_log[vs + i], exp_d); end
        end
        stop_run();
        n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL sweep_idle_done: got %b expected 0", o_done); end
    endtask

    task automatic test_stride;
        int rs, idx;
        bit seen;
        logic [31:0] exp_a;
        setup(5, 5, 3, 2);
        rs = rd_cnt;
        start_run();
        for (int i = 0; i < 31; i++) begin
            i_data_req = 1'b1;
            tick();
        end
        i_data_req = 1'b0;
        wait_done(20, seen);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL stride_done: got %b expected 1 within 20 cycles", seen); end
        n_cmp++; if (rd_cnt - rs !== 30) begin n_err++; $display("FAIL stride_reads: got %0d expected 30", rd_cnt - rs); end
        n_cmp++; if (rd_log[rs + 15] !== 32'h10A) begin n_err++; $display("FAIL stride_addr16: got %h expected 0000010a", rd_log[rs + 15]); end
        idx = 0;
        for (int r = 0; r <= 2; r += 2)
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < 5; c++) begin
                    exp_a = BASE + 32'((r + k) * 5 + c);
                    n_cmp++; if (rd_log[rs + idx] !== exp_a) begin n_err++; $display("FAIL stride_addr[%0d]: got %h expected %h", idx, rd_log[rs + idx], exp_a); end
                    idx++;
                end
        stop_run();
    endtask

    task automatic test_backpressure;
        int rs, vs;
        bit seen;
        logic [PIX_W-1:0] exp_d;
        setup(8, 8, 3, 1);
        rs = rd_cnt; vs = vld_cnt;
        mem_stall = 1'b1;
        start_run();
        for (int i = 0; i < 9; i++) begin
            i_data_req = 1'b1;
            tick();
        end
        i_data_req = 1'b0;
        repeat (11) tick();
        n_cmp++; if (rd_cnt - rs !== 8) begin n_err++; $display("FAIL bp_reads_stalled: got %0d expected 8", rd_cnt - rs); end
        n_cmp++; if (vld_cnt - vs !== 0) begin n_err++; $display("FAIL bp_beats_stalled: got %0d expected 0", vld_cnt - vs); end
        mem_stall = 1'b0;
        repeat (15) tick();
        n_cmp++; if (rd_cnt - rs !== 9) begin n_err++; $display("FAIL bp_pending_issued: got %0d expected 9", rd_cnt - rs); end
        n_cmp++; if (rd_log[rs + 8] !== BASE + 32'h8) begin n_err++; $display("FAIL bp_pending_addr: got %h expected %h", rd_log[rs + 8], BASE + 32'h8); end
        i_data_req = 1'b1;
        tick();
        i_data_req = 1'b0;
        repeat (5) tick();
        n_cmp++; if (rd_cnt - rs !== 10) begin n_err++; $display("FAIL bp_reads_total: got %0d expected 10", rd_cnt - rs); end
        n_cmp++; if (vld_cnt - vs !== 10) begin n_err++; $display("FAIL bp_beats_total: got %0d expected 10", vld_cnt - vs); end
        for (int i = 0; i < 10; i++) begin
            exp_d = PIX_W'((BASE + 32'(i)) ^ PAT);
            n_cmp++; if (vd_log[vs + i] !== exp_d) begin n_err++; $display("FAIL bp_data[%0d]: got %h expected %h", i, vd_log[vs + i], exp_d); end
        end
        i_data_end = 1'b1;
        tick();
        i_data_end = 1'b0;
        wait_done(10, seen);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL bp_done: got %b expected 1 within 10 cycles", seen); end
        stop_run();
    endtask

    task automatic test_early_end;
        int rs, vs, vld_at_done;
        bit seen;
        logic [31:0] exp_a;
        setup(4, 4, 3, 1);
        rs = rd_cnt; vs = vld_cnt;
        vld_at_done = -1;
        seen = 1'b0;
        start_run();
        for (int i = 0; i < 5; i++) begin
            i_data_req = 1'b1;
            i_data_end = (i == 4);
            tick();
        end
        i_data_end = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (o_done === 1'b1) begin
                seen = 1'b1;
                vld_at_done = vld_cnt - vs;
            end
        end
        repeat (4) tick();
        i_data_req = 1'b0;
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL early_done: got %b expected 1 within 20 cycles", seen); end
        n_cmp++; if (vld_at_done !== 5) begin n_err++; $display("FAIL early_beats_at_done: got %0d expected 5", vld_at_done); end
        n_cmp++; if (rd_cnt - rs !== 5) begin n_err++; $display("FAIL early_reads: got %0d expected 5", rd_cnt - rs); end
        for (int i = 0; i < 5; i++) begin
            exp_a = BASE + 32'(i);
            n_cmp++; if (rd_log[rs + i] !== exp_a) begin n_err++; $display("FAIL early_addr[%0d]: got %h expected %h", i, rd_log[rs + i], exp_a); end
        end
`ifdef INPUT_DATA_FEEDER_DBG_EN
        n_cmp++; if (o_dbg_addr_reg !== 32'h104) begin n_err++; $display("FAIL early_dbg_addr: got %h expected 00000104", o_dbg_addr_reg); end
        n_cmp++; if (o_dbg_knlinex_cnt !== 32'h1) begin n_err++; $display("FAIL early_dbg_kl: got %h expected 00000001", o_dbg_knlinex_cnt); end
`else
        n_cmp++; if (o_dbg_addr_reg !== 32'h0) begin n_err++; $display("FAIL early_dbg_addr: got %h expected 0", o_dbg_addr_reg); end
        n_cmp++; if (o_dbg_knlinex_cnt !== 32'h0) begin n_err++; $display("FAIL early_dbg_kl: got %h expected 0", o_dbg_knlinex_cnt); end
`endif
        stop_run();
    endtask

    task automatic test_reset_mid;
        int rs;
        bit seen;
        setup(4, 4, 3, 1);
        start_run();
        for (int i = 0; i < 7; i++) begin
            i_data_req = 1'b1;
            tick();
        end
        i_data_req = 1'b0;
        n_cmp++; if (mem_rden !== 1'b1) begin n_err++; $display("FAIL midrst_pre_rden: got %b expected 1", mem_rden); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_rden !== 1'b0) begin n_err++; $display("FAIL midrst_rden: got %b expected 0", mem_rden); end
        n_cmp++; if (mem_radd !== 32'h0) begin n_err++; $display("FAIL midrst_radd: got %h expected 0", mem_radd); end
        n_cmp++; if (o_data_vld !== 1'b0) begin n_err++; $display("FAIL midrst_vld: got %b expected 0", o_data_vld); end
        n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b expected 0", o_done); end
        tick();
        tick();
        rst_n = 1'b1;
        rs = rd_cnt;
        tick();
        i_data_req = 1'b1;
        tick();
        i_data_req = 1'b0;
        tick();
        n_cmp++; if (rd_cnt - rs !== 1) begin n_err++; $display("FAIL midrst_restart_reads: got %0d expected 1", rd_cnt - rs); end
        n_cmp++; if (rd_log[rs] !== BASE) begin n_err++; $display("FAIL midrst_restart_addr: got %h expected %h", rd_log[rs], BASE); end
        i_data_end = 1'b1;
        tick();
        i_data_end = 1'b0;
        wait_done(10, seen);
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL midrst_done_after: got %b expected 1 within 10 cycles", seen); end
        stop_run();
    endtask

    task automatic test_degenerate;
        int rs, ticks;
        bit seen;
        setup(4, 4, 5, 1);
        rs = rd_cnt;
        seen = 1'b0;
        ticks = 0;
        i_conf_ctrl = 32'd1;
        i_data_req  = 1'b1;
        tick(); ticks++;
        n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL degen_done_early: got %b expected 0", o_done); end
        while (ticks < 3 && !seen) begin
            tick(); ticks++;
            if (o_done === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL degen_done: got %b expected 1 by 3 cycles", seen); end
        n_cmp++; if (rd_cnt - rs !== 0) begin n_err++; $display("FAIL degen_reads: got %0d expected 0", rd_cnt - rs); end
        i_conf_ctrl = 32'd0;
        tick();
        tick();
        n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL degen_idle_done: got %b expected 0", o_done); end
        tick();
        tick();
        i_data_req = 1'b0;
        n_cmp++; if (rd_cnt - rs !== 0) begin n_err++; $display("FAIL degen_idle_reads: got %0d expected 0", rd_cnt - rs); end
    endtask

    initial begin
        rst_n              = 1'b0;
        i_conf_ctrl        = '0;
        i_conf_inputshape  = '0;
        i_conf_kernelshape = '0;
        i_conf_kernelsize  = '0;
        i_conf_inbase      = '0;
        i_data_req         = 1'b0;
        i_data_end         = 1'b0;
        mem_stall          = 1'b0;
        repeat (2) tick();
        test_reset();
        rst_n = 1'b1;
        tick();

        test_full_sweep();
        test_stride();
        test_backpressure();
        test_early_end();
        test_reset_mid();
        test_degenerate();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
